// File: rtl/sdram_pkg.sv
// Shared types and default timing for the channel 1 page-mode scheduler.
// The refresh period is shared with the controller's own refresh setting.
package sdram_pkg;

    localparam int ROW_W = 13;
    localparam int COL_W = 8;
    localparam int TMR_W = 4;

    localparam int DEF_REFRESH_INTERVAL = 780;
    localparam int DEF_T_ACT   = 2;
    localparam int DEF_T_PCH   = 2;
    localparam int DEF_T_REF   = 8;
    localparam int DEF_T_WR    = 2;
    localparam int DEF_T_RD    = 4;
    localparam int DEF_RD_DATA = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCH,
        S_ACT,
        S_ACCESS,
        S_REF,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic             rnw;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [31:0]      din;
        logic [3:0]       be;
    } host_cmd_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh counter; raises ref_pend on each wrap until cleared.
import sdram_pkg::*;

module sdram_refresh_timer #(
    parameter int INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic ref_pend
);

    localparam int CW = $clog2(INTERVAL);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(INTERVAL - 1));

    // A wrap coinciding with a clear keeps the new request pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            ref_pend <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                ref_pend <= 1'b1;
            else if (clear)
                ref_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_ch1_sched.sv
// Page-mode scheduler: turns host word requests into timed act/req/pch/ref
// pulses for SDRAM channel 1, keeping one row of bank 0 open.
import sdram_pkg::*;

module sdram_ch1_sched #(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int T_ACT   = DEF_T_ACT,
    parameter int T_PCH   = DEF_T_PCH,
    parameter int T_REF   = DEF_T_REF,
    parameter int T_WR    = DEF_T_WR,
    parameter int T_RD    = DEF_T_RD,
    parameter int RD_DATA = DEF_RD_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_req,
    input  logic        host_rnw,
    input  logic [20:0] host_addr,
    input  logic [31:0] host_din,
    input  logic [3:0]  host_be,
    output logic        host_ack,
    output logic [31:0] host_dout,
    output logic        host_valid,
    output logic [12:0] ch1_caddr,
    output logic [31:0] ch1_din,
    output logic [3:0]  ch1_be,
    output logic        ch1_rnw,
    output logic        ch1_req,
    output logic        ch1_act,
    output logic        ch1_pch,
    output logic        ch1_ref,
    input  logic [31:0] ch1_dout,
    output logic        busy
);

    localparam logic [TMR_W-1:0] TL_ACT = TMR_W'(T_ACT - 1);
    localparam logic [TMR_W-1:0] TL_PCH = TMR_W'(T_PCH - 1);
    localparam logic [TMR_W-1:0] TL_REF = TMR_W'(T_REF - 1);
    localparam logic [TMR_W-1:0] TL_WR  = TMR_W'(T_WR - 1);
    localparam logic [TMR_W-1:0] TL_RD  = TMR_W'(T_RD - 1);

    state_t             state;
    host_cmd_t          cmd;
    logic [TMR_W-1:0]   tmr;
    logic               row_open;
    logic [ROW_W-1:0]   open_row;
    logic               ref_seq;
    logic               ref_pend;
    logic               ref_clear;
    logic               row_hit;
    logic [RD_DATA-2:0] rd_pipe;

    assign busy      = (state != S_IDLE);
    assign ref_clear = (state == S_REF) && (tmr == '0);
    assign row_hit   = row_open && (open_row == host_addr[20:8]);

    sdram_refresh_timer #(
        .INTERVAL(REFRESH_INTERVAL)
    ) u_refresh (
        .clk     (clk),
        .reset   (reset),
        .clear   (ref_clear),
        .ref_pend(ref_pend)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd       <= '0;
            tmr       <= '0;
            row_open  <= 1'b0;
            open_row  <= '0;
            ref_seq   <= 1'b0;
            host_ack  <= 1'b0;
            ch1_caddr <= '0;
            ch1_din   <= '0;
            ch1_be    <= '0;
            ch1_rnw   <= 1'b0;
            ch1_req   <= 1'b0;
            ch1_act   <= 1'b0;
            ch1_pch   <= 1'b0;
            ch1_ref   <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            ch1_req  <= 1'b0;
            ch1_act  <= 1'b0;
            ch1_pch  <= 1'b0;
            ch1_ref  <= 1'b0;
            if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (ref_pend) begin
                            ref_seq <= 1'b1;
                            state   <= row_open ? S_PCH : S_REF;
                        end else if (host_req) begin
                            host_ack <= 1'b1;
                            ref_seq  <= 1'b0;
                            cmd      <= '{rnw: host_rnw,
                                          row: host_addr[20:8],
                                          col: host_addr[7:0],
                                          din: host_din,
                                          be:  host_be};
                            if (row_hit)
                                state <= S_ACCESS;
                            else if (row_open)
                                state <= S_PCH;
                            else
                                state <= S_ACT;
                        end
                    end
                    S_PCH: begin
                        ch1_pch  <= 1'b1;
                        row_open <= 1'b0;
                        tmr      <= TL_PCH;
                        state    <= ref_seq ? S_REF : S_ACT;
                    end
                    S_ACT: begin
                        ch1_caddr <= cmd.row;
                        ch1_act   <= 1'b1;
                        row_open  <= 1'b1;
                        open_row  <= cmd.row;
                        tmr       <= TL_ACT;
                        state     <= S_ACCESS;
                    end
                    S_ACCESS: begin
                        ch1_caddr <= {{(ROW_W-COL_W){1'b0}}, cmd.col};
                        ch1_rnw   <= cmd.rnw;
                        ch1_din   <= cmd.din;
                        ch1_be    <= cmd.be;
                        ch1_req   <= 1'b1;
                        tmr       <= cmd.rnw ? TL_RD : TL_WR;
                        state     <= S_WAIT;
                    end
                    S_REF: begin
                        ch1_ref <= 1'b1;
                        tmr     <= TL_REF;
                        state   <= S_WAIT;
                    end
                    S_WAIT: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Read data tracks the req pulse on its own, so it may overlap the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe    <= '0;
            host_valid <= 1'b0;
            host_dout  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[RD_DATA-3:0], ch1_req & ch1_rnw};
            host_valid <= rd_pipe[RD_DATA-2];
            if (rd_pipe[RD_DATA-2])
                host_dout <= ch1_dout;
        end
    end

endmodule

// File: tb/tb_sdram_ch1_sched.sv
// Directed bench for sdram_ch1_sched with a small channel-side memory model.
// Pulse times are recorded in posedges since reset release.
module tb_sdram_ch1_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        host_req = 1'b0;
    logic        host_rnw = 1'b0;
    logic [20:0] host_addr = '0;
    logic [31:0] host_din = '0;
    logic [3:0]  host_be = '0;
    logic        host_ack;
    logic [31:0] host_dout;
    logic        host_valid;
    logic [12:0] ch1_caddr;
    logic [31:0] ch1_din;
    logic [3:0]  ch1_be;
    logic        ch1_rnw;
    logic        ch1_req;
    logic        ch1_act;
    logic        ch1_pch;
    logic        ch1_ref;
    logic [31:0] ch1_dout = '0;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    sdram_ch1_sched dut (
        .clk       (clk),
        .reset     (reset),
        .host_req  (host_req),
        .host_rnw  (host_rnw),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_be   (host_be),
        .host_ack  (host_ack),
        .host_dout (host_dout),
        .host_valid(host_valid),
        .ch1_caddr (ch1_caddr),
        .ch1_din   (ch1_din),
        .ch1_be    (ch1_be),
        .ch1_rnw   (ch1_rnw),
        .ch1_req   (ch1_req),
        .ch1_act   (ch1_act),
        .ch1_pch   (ch1_pch),
        .ch1_ref   (ch1_ref),
        .ch1_dout  (ch1_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int edges;
    always @(posedge clk or posedge reset)
        if (reset) edges <= 0;
        else edges <= edges + 1;

    int act_cnt = 0, req_cnt = 0, pch_cnt = 0, ref_cnt = 0, ack_cnt = 0;
    int act_t = -1, req_t = -1, pch_t = -1, ref_t = -1, ack_t = -1, val_t = -1;
    logic [12:0] act_caddr, req_caddr, mrow;
    logic        req_rnw;
    logic [31:0] req_din, val_dout, w;
    logic [3:0]  req_be;
    logic [31:0] mem [int];
    int          key;

    // Channel-side model: remembers the activated row and serves reads.
    always @(negedge clk) begin
        if (!reset) begin
            if (ch1_act) begin
                act_cnt++; act_t = edges;
                act_caddr = ch1_caddr; mrow = ch1_caddr;
            end
            if (ch1_req) begin
                req_cnt++; req_t = edges;
                req_caddr = ch1_caddr; req_rnw = ch1_rnw;
                req_din = ch1_din; req_be = ch1_be;
                key = int'({mrow, ch1_caddr[7:0]});
                w = mem.exists(key) ? mem[key] : (32'hA500_0000 | 32'(key));
                if (!ch1_rnw) begin
                    for (int i = 0; i < 4; i++)
                        if (ch1_be[i]) w[i*8 +: 8] = ch1_din[i*8 +: 8];
                    mem[key] = w;
                end else begin
                    ch1_dout = w;
                end
            end
            if (ch1_pch) begin pch_cnt++; pch_t = edges; end
            if (ch1_ref) begin ref_cnt++; ref_t = edges; end
            if (host_ack) begin ack_cnt++; ack_t = edges; end
            if (host_valid) begin val_t = edges; val_dout = host_dout; end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic host_op(input logic rnw, input logic [20:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        int n;
        int a0;
        a0 = ack_cnt;
        host_rnw = rnw; host_addr = a; host_din = d; host_be = b;
        host_req = 1'b1;
        n = 0;
        while (ack_cnt == a0 && n < 2000) begin tick(); n++; end
        host_req = 1'b0;
        compared++;
        if (ack_cnt == a0) begin
            mismatched++;
            $display("FAIL ack_timeout addr=%h: no ack in %0d cycles", a, n);
        end
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        repeat (8) tick();
    endtask

    task automatic test_reset();
        logic [88:0] obs;
        reset = 1'b1;
        #2;
        obs = {host_ack, host_dout, host_valid, ch1_caddr, ch1_din, ch1_be,
               ch1_rnw, ch1_req, ch1_act, ch1_pch, ch1_ref, busy};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        apply_reset();
        repeat (3) tick();
        compared++;
        if ({busy, host_ack} !== 2'b00) begin
            mismatched++;
            $display("FAIL idle_after_reset: busy/ack got %b want 00", {busy, host_ack});
        end
    endtask

    task automatic test_read_miss();
        int a0;
        a0 = act_cnt;
        host_op(1'b1, 21'h00105, 32'h0, 4'h0);
        compared++;
        if (act_cnt !== a0 + 1 || act_caddr !== 13'h0001) begin
            mismatched++;
            $display("FAIL rd_act: cnt %0d caddr %h want %0d 0001", act_cnt, act_caddr, a0 + 1);
        end
        compared++;
        if (act_t - ack_t !== 1) begin
            mismatched++;
            $display("FAIL ack_to_act: got %0d want 1", act_t - ack_t);
        end
        compared++;
        if (req_t - act_t !== 2 || req_caddr !== 13'h0005 || req_rnw !== 1'b1) begin
            mismatched++;
            $display("FAIL rd_req: gap %0d caddr %h rnw %b want 2 0005 1",
                     req_t - act_t, req_caddr, req_rnw);
        end
        compared++;
        if (val_t - req_t !== 6 || val_dout !== 32'hA500_0105) begin
            mismatched++;
            $display("FAIL rd_data: lat %0d data %h want 6 a5000105", val_t - req_t, val_dout);
        end
    endtask

    task automatic test_page_hit();
        int a0, p0;
        a0 = act_cnt; p0 = pch_cnt;
        host_op(1'b0, 21'h00107, 32'hDEAD_BEEF, 4'hF);
        compared++;
        if (act_cnt !== a0 || req_caddr !== 13'h0007 || req_rnw !== 1'b0 ||
            req_din !== 32'hDEAD_BEEF || req_be !== 4'hF) begin
            mismatched++;
            $display("FAIL wr_hit: acts %0d caddr %h rnw %b din %h be %h want %0d 0007 0 deadbeef f",
                     act_cnt, req_caddr, req_rnw, req_din, req_be, a0);
        end
        host_op(1'b1, 21'h00107, 32'h0, 4'h0);
        compared++;
        if (act_cnt !== a0 || pch_cnt !== p0 || val_dout !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL rd_hit: acts %0d pchs %0d data %h want %0d %0d deadbeef",
                     act_cnt, pch_cnt, val_dout, a0, p0);
        end
        host_op(1'b0, 21'h00108, 32'h1122_3344, 4'b0011);
        host_op(1'b1, 21'h00108, 32'h0, 4'h0);
        compared++;
        if (val_dout !== 32'hA500_3344) begin
            mismatched++;
            $display("FAIL byte_enable: got %h want a5003344", val_dout);
        end
    endtask

    task automatic test_row_miss();
        int a0, p0;
        a0 = act_cnt; p0 = pch_cnt;
        host_op(1'b1, 21'h00203, 32'h0, 4'h0);
        compared++;
        if (pch_cnt !== p0 + 1 || act_t - pch_t !== 2 || act_caddr !== 13'h0002) begin
            mismatched++;
            $display("FAIL miss_pch_act: pchs %0d gap %0d caddr %h want %0d 2 0002",
                     pch_cnt, act_t - pch_t, act_caddr, p0 + 1);
        end
        compared++;
        if (req_t - act_t !== 2 || req_caddr !== 13'h0003 || val_dout !== 32'hA500_0203) begin
            mismatched++;
            $display("FAIL miss_req: gap %0d caddr %h data %h want 2 0003 a5000203",
                     req_t - act_t, req_caddr, val_dout);
        end
        a0 = act_cnt;
        host_op(1'b1, 21'h00204, 32'h0, 4'h0);
        compared++;
        if (act_cnt !== a0 || val_dout !== 32'hA500_0204) begin
            mismatched++;
            $display("FAIL new_row_open: acts %0d data %h want %0d a5000204", act_cnt, val_dout, a0);
        end
    endtask

    task automatic test_refresh();
        logic b791, b792;
        int a0, p0;
        b791 = 1'b0; b792 = 1'b1;
        while (edges < 795) begin
            tick();
            if (edges == 791) b791 = busy;
            if (edges == 792) b792 = busy;
        end
        compared++;
        if (pch_t !== 782 || ref_t !== 784) begin
            mismatched++;
            $display("FAIL refresh_timing: pch@%0d ref@%0d want 782 784", pch_t, ref_t);
        end
        compared++;
        if (b791 !== 1'b1 || b792 !== 1'b0) begin
            mismatched++;
            $display("FAIL refresh_idle: busy@791 %b busy@792 %b want 1 0", b791, b792);
        end
        a0 = act_cnt; p0 = pch_cnt;
        host_op(1'b1, 21'h00203, 32'h0, 4'h0);
        compared++;
        if (act_cnt !== a0 + 1 || pch_cnt !== p0 || act_caddr !== 13'h0002) begin
            mismatched++;
            $display("FAIL after_refresh: acts %0d pchs %0d caddr %h want %0d %0d 0002",
                     act_cnt, pch_cnt, act_caddr, a0 + 1, p0);
        end
    endtask

    task automatic test_ref_vs_req();
        apply_reset();
        while (edges < 780) tick();
        host_op(1'b1, 21'h00300, 32'h0, 4'h0);
        compared++;
        if (ref_t !== 782 || ack_t !== 791 || ack_t - ref_t < 8) begin
            mismatched++;
            $display("FAIL ref_priority: ref@%0d ack@%0d want 782 791", ref_t, ack_t);
        end
        compared++;
        if (act_t !== 792 || act_caddr !== 13'h0003 || val_dout !== 32'hA500_0300) begin
            mismatched++;
            $display("FAIL req_after_ref: act@%0d caddr %h data %h want 792 0003 a5000300",
                     act_t, act_caddr, val_dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [88:0] obs;
        int a0, p0, r0, k0, n;
        a0 = act_cnt; k0 = ack_cnt;
        host_rnw = 1'b1; host_addr = 21'h00500; host_req = 1'b1;
        n = 0;
        while (act_cnt == a0 && n < 200) begin
            tick(); n++;
            if (ack_cnt != k0) host_req = 1'b0;
        end
        host_req = 1'b0;
        compared++;
        if (act_cnt == a0) begin
            mismatched++;
            $display("FAIL mid_act_timeout: no act in %0d cycles", n);
        end
        tick();
        reset = 1'b1;
        #1;
        obs = {host_ack, host_dout, host_valid, ch1_caddr, ch1_din, ch1_be,
               ch1_rnw, ch1_req, ch1_act, ch1_pch, ch1_ref, busy};
        compared++;
        if (obs !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got %h want 0", obs);
        end
        repeat (2) tick();
        reset = 1'b0;
        r0 = req_cnt;
        repeat (10) tick();
        compared++;
        if (req_cnt !== r0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL no_req_after_reset: reqs %0d busy %b want %0d 0", req_cnt, busy, r0);
        end
        a0 = act_cnt; p0 = pch_cnt;
        host_op(1'b1, 21'h00500, 32'h0, 4'h0);
        compared++;
        if (act_cnt !== a0 + 1 || pch_cnt !== p0 || act_caddr !== 13'h0005) begin
            mismatched++;
            $display("FAIL restart_act: acts %0d pchs %0d caddr %h want %0d %0d 0005",
                     act_cnt, pch_cnt, act_caddr, a0 + 1, p0);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_page_hit();
        test_row_miss();
        test_refresh();
        test_ref_vs_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
